// File: rtl/ad_ip_jesd204_tpl_dac_upack.sv
// rtl/ad_ip_jesd204_tpl_dac_upack.sv - DAC DMA channel unpacker with padding strip and underflow tracking
module ad_ip_jesd204_tpl_dac_upack #(
  parameter int NUM_CHANNELS         = 4,
  parameter int SAMPLES_PER_CHANNEL  = 1,
  parameter int BITS_PER_SAMPLE      = 16,
  parameter int DMA_BITS_PER_SAMPLE  = 16,
  parameter int PADDING_TO_MSB_LSB_N = 0
) (
  input  logic                                                          clk,
  input  logic                                                          resetn,
  input  logic [NUM_CHANNELS-1:0]                                       enable,
  input  logic                                                          s_valid,
  output logic                                                          s_ready,
  input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*DMA_BITS_PER_SAMPLE-1:0] s_data,
  input  logic                                                          m_ready,
  output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*BITS_PER_SAMPLE-1:0]   m_data,
  output logic                                                          dunf,
  output logic [15:0]                                                   dunf_count,
  output logic                                                          enable_error
);

  localparam int W     = NUM_CHANNELS * SAMPLES_PER_CHANNEL;
  localparam int IW    = W * DMA_BITS_PER_SAMPLE;
  localparam int OW    = W * BITS_PER_SAMPLE;
  localparam int CW    = $clog2(NUM_CHANNELS + 1);
  localparam int LOG_N = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] enable_q;
  logic [IW-1:0]           buf_data;
  logic                    buf_valid;
  logic [CW-1:0]           grp;

  logic [CW-1:0]           num_en;
  logic [CW-1:0]           rank [NUM_CHANNELS];
  logic [CW-1:0]           last_grp;
  logic [OW-1:0]           grp_data;
  logic                    en_change;
  logic                    consume;
  logic                    consume_last;
  logic                    accept;

  // A usable pattern enables a power-of-two number of channels (at least one).
  function automatic logic bad_pattern(input logic [NUM_CHANNELS-1:0] en);
    int n;
    n = 0;
    for (int c = 0; c < NUM_CHANNELS; c++) n += int'(en[c]);
    return (n == 0) || ((n & (n - 1)) != 0);
  endfunction

  // Count enabled channels and give each enabled channel its position among them.
  always_comb begin
    num_en = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rank[c] = num_en;
      num_en  = num_en + CW'(enable_q[c]);
    end
  end

  // Index of the last output group in a beat: NUM_CHANNELS / enabled - 1.
  always_comb begin
    last_grp = '0;
    for (int k = 0; k <= LOG_N; k++) begin
      if (int'(num_en) == (1 << k)) last_grp = CW'((NUM_CHANNELS >> k) - 1);
    end
  end

  // Gather the current group's samples onto their channel slots, stripping padding.
  always_comb begin
    int idx;
    idx      = 0;
    grp_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int s = 0; s < SAMPLES_PER_CHANNEL; s++) begin
        idx = int'(grp) * int'(num_en) * SAMPLES_PER_CHANNEL + s * int'(num_en) + int'(rank[c]);
        if (enable_q[c] && idx < W) begin
          if (PADDING_TO_MSB_LSB_N != 0)
            grp_data[(c*SAMPLES_PER_CHANNEL+s)*BITS_PER_SAMPLE +: BITS_PER_SAMPLE] =
              buf_data[idx*DMA_BITS_PER_SAMPLE +: BITS_PER_SAMPLE];
          else
            grp_data[(c*SAMPLES_PER_CHANNEL+s)*BITS_PER_SAMPLE +: BITS_PER_SAMPLE] =
              buf_data[idx*DMA_BITS_PER_SAMPLE + DMA_BITS_PER_SAMPLE - BITS_PER_SAMPLE +: BITS_PER_SAMPLE];
        end
      end
    end
  end

  assign en_change    = (enable != enable_q);
  assign consume      = m_ready && buf_valid;
  assign consume_last = consume && (grp == last_grp);
  assign s_ready      = !buf_valid || (m_ready && (grp == last_grp)) || enable_error;
  assign accept       = s_valid && s_ready && !enable_error;

  // Beat buffer, group pointer, enable tracking and request-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable_q     <= '0;
      enable_error <= 1'b0;
      buf_data     <= '0;
      buf_valid    <= 1'b0;
      grp          <= '0;
      m_data       <= '0;
      dunf         <= 1'b0;
      dunf_count   <= '0;
    end else begin
      enable_q     <= enable;
      enable_error <= bad_pattern(enable);

      // A changed enable set invalidates the buffered beat's layout; error mode discards beats.
      if (en_change || enable_error) begin
        buf_valid <= 1'b0;
        grp       <= '0;
      end else begin
        if (consume) grp <= consume_last ? '0 : grp + CW'(1);
        if (accept) begin
          buf_data  <= s_data;
          buf_valid <= 1'b1;
        end else if (consume_last) begin
          buf_valid <= 1'b0;
        end
      end

      if (m_ready) begin
        m_data <= (consume && !enable_error) ? grp_data : '0;
        dunf   <= !buf_valid && !enable_error;
        if (!buf_valid && !enable_error && dunf_count != 16'hffff)
          dunf_count <= dunf_count + 16'd1;
      end else begin
        dunf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_upack.md
# ad_ip_jesd204_tpl_dac_upack

Channel unpacker and padding stripper between the DAC DMA stream and the TPL DAC core, on the link clock. It takes a packed DMA beat that holds samples only for enabled channels, strips DMA padding bits per sample, and distributes samples over the full NUM_CHANNELS × SAMPLES_PER_CHANNEL output word on each core request. Disabled channels are zero-filled. Underflows are flagged and counted. It replaces the purely combinational padding drop at the TPL top level and adds sparse-channel support.

## Interface
Parameters:
- NUM_CHANNELS, 4: converter channels (M). Must be a power of two, ≤16.
- SAMPLES_PER_CHANNEL, 1: samples per channel per beat (DATA_PATH_WIDTH).
- BITS_PER_SAMPLE, 16: output sample width (JESD NP).
- DMA_BITS_PER_SAMPLE, 16: DMA sample width. Must be ≥ BITS_PER_SAMPLE.
- PADDING_TO_MSB_LSB_N, 0: 1 means padding sits in the MSBs (keep the low bits); 0 means padding sits in the LSBs (keep the high bits).

Ports (W = NUM_CHANNELS*SAMPLES_PER_CHANNEL):
- clk, input, 1: link clock; all logic.
- resetn, input, 1: asynchronous active-low reset.
- enable, input, NUM_CHANNELS: channel enables, quasi-static.
- s_valid, input, 1: DMA beat valid.
- s_ready, output, 1: DMA beat accept.
- s_data, input, W*DMA_BITS_PER_SAMPLE: packed DMA beat; sample k at bits [k*DMA_BITS_PER_SAMPLE +: DMA_BITS_PER_SAMPLE].
- m_ready, input, 1: core request strobe (dac_valid).
- m_data, output, W*BITS_PER_SAMPLE: channel c, sample s at index c*SAMPLES_PER_CHANNEL+s.
- dunf, output, 1: underflow pulse.
- dunf_count, output, 16: saturating underflow counter.
- enable_error, output, 1: unsupported enable pattern.

## Operation
- E = popcount(enable_q); R = NUM_CHANNELS/E. Legal values of E: powers of two, 1..NUM_CHANNELS. E=0 or a non-power-of-two sets enable_error=1.
- Input beat holds W samples, which covers R output groups of E*SAMPLES_PER_CHANNEL samples each.
- In group r, the j-th enabled channel (ascending index), sample s, takes input sample r*E*SAMPLES_PER_CHANNEL + s*E + j, after padding strip.
- Padding strip: if PADDING_TO_MSB_LSB_N=1, take bits [BITS_PER_SAMPLE-1:0]; else take the top BITS_PER_SAMPLE bits of each DMA sample.
- Disabled channels output 0.
- State: buf (one beat), buf_valid, grp counter 0..R-1, enable_q.
- s_ready = !buf_valid || (m_ready && grp==R-1) || enable_error.
- On s_valid && s_ready with no error: buf←s_data, buf_valid←1.
- On m_ready with buf_valid:
  - m_data←group grp.
  - If grp==R-1: grp←0, and buf_valid←0 unless a new beat is accepted on the same edge.
  - Else grp←grp+1.
- On m_ready with !buf_valid:
  - m_data←0, dunf←1, dunf_count←dunf_count+1, saturating at 0xFFFF.
- enable_error=1:
  - Beats are accepted and discarded, buf_valid held 0.
  - m_data←0 on m_ready; dunf is not asserted.
- enable change: enable_q←enable every cycle. When enable_q differs from enable, on the next edge buf_valid←0 and grp←0, and the buffered beat is dropped. m_data holds its value until the next m_ready.
- Without m_ready: m_data holds and dunf=0.

## Timing
- Reset values: m_data=0, dunf=0, dunf_count=0, enable_error=0, buf_valid=0, grp=0, enable_q=0. s_ready is 1 during and after reset.
- m_data, dunf, dunf_count, and enable_error are registered. m_data reflects the request one cycle after the m_ready edge.
- Latency from beat accept to first use: the beat is captured at edge n. An m_ready at edge n+1 or later loads group 0.
- Throughput: one beat per R requests. With R=1 and m_ready continuous, s_ready stays high and there are no bubbles.
- Simultaneous last-group consume and new accept: no bubble and no underflow.
- Reset asserted mid-beat: the buffer is dropped asynchronously and every output returns to its reset value.

## Test plan
- N=4, SPC=2, BPS=DMA=16, enable=4'hF. One beat with samples 0x0000..0x0007, then m_ready. Required: ch0={s1=0x0004,s0=0x0000}, ch1={0x0005,0x0001}, ch2={0x0006,0x0002}, ch3={0x0007,0x0003}; dunf=0.
- Same config, enable=4'b0101, beat 0x0010..0x0017, m_ready held 2 cycles.
  - Group0: ch0={0x0012,0x0010}, ch2={0x0013,0x0011}.
  - Group1: ch0={0x0016,0x0014}, ch2={0x0017,0x0015}.
  - ch1 and ch3 are 0 throughout; s_ready is low until the last group edge.
- No s_valid, m_ready high 3 cycles: m_data=0, dunf high 3 cycles, dunf_count=3. Preload 0xFFFE and continue: the count holds at 0xFFFF.
- DMA=32, BPS=16, sample 0xABCD1234: PADDING_TO_MSB_LSB_N=0 outputs 0xABCD; PADDING_TO_MSB_LSB_N=1 outputs 0x1234.
- enable=4'b0111: enable_error=1, s_ready=1, beats discarded, m_data=0, dunf=0. Change to 4'hF: error clears and the next beat unpacks normally.
- Buffer full in mid-group (R=2, grp=1), resetn pulsed low: all outputs 0 immediately, grp=0, and the next beat restarts at group 0.
